// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: column drive, 2-flop row sync, press/release debounce, one-clock key codes.
// Optional auto-repeat while held is compiled in with `define KEYPAD_REPEAT_EN.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [4:0] value
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD} state_t;

  logic [3:0]    rows_meta, rows_sync;
  logic [DW-1:0] div;
  logic          tick;
  state_t        state, state_nxt;
  logic [1:0]    col, col_nxt, row, row_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    value_nxt;
  logic          press, row_low;
  logic [1:0]    press_row;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(RMAX + 1);
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          rep_phase, rep_phase_nxt;
`endif

  assign tick    = (div == DW'(SCAN_DIV - 1));
  assign press   = ~&rows_sync;
  assign row_low = ~rows_sync[row];
  assign columns = ~(4'b0001 << col);

  // Lowest row index wins when several rows are low
  always_comb begin
    press_row = 2'd3;
    if (!rows_sync[0])      press_row = 2'd0;
    else if (!rows_sync[1]) press_row = 2'd1;
    else if (!rows_sync[2]) press_row = 2'd2;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta <= 4'hF;
      rows_sync <= 4'hF;
      div       <= '0;
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      cnt       <= '0;
      value     <= 5'd0;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
      div       <= tick ? '0 : div + DW'(1);
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      cnt       <= cnt_nxt;
      value     <= value_nxt;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt  <= hold_cnt_nxt;
      rep_phase <= rep_phase_nxt;
`endif
    end
  end

  // cnt is the press count in PRESS_DB and the release count in HELD
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    cnt_nxt   = cnt;
    value_nxt = 5'd0;
`ifdef KEYPAD_REPEAT_EN
    hold_cnt_nxt  = hold_cnt;
    rep_phase_nxt = rep_phase;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (press) begin
            row_nxt = press_row;
            if (DEBOUNCE_CNT <= 1) begin
              value_nxt = {1'b1, col, press_row};
              cnt_nxt   = '0;
              state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
              hold_cnt_nxt  = '0;
              rep_phase_nxt = 1'b0;
`endif
            end else begin
              cnt_nxt   = CW'(1);
              state_nxt = PRESS_DB;
            end
          end else begin
            col_nxt = col + 2'd1;
          end
        end
        PRESS_DB: begin
          if (row_low) begin
            cnt_nxt = cnt + CW'(1);
            if (cnt_nxt == CW'(DEBOUNCE_CNT)) begin
              value_nxt = {1'b1, col, row};
              cnt_nxt   = '0;
              state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
              hold_cnt_nxt  = '0;
              rep_phase_nxt = 1'b0;
`endif
            end
          end else begin
            state_nxt = SCAN;
            col_nxt   = col + 2'd1;
          end
        end
        HELD: begin
          if (row_low) begin
            cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
            hold_cnt_nxt = hold_cnt + HW'(1);
            if (hold_cnt_nxt == (rep_phase ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY))) begin
              value_nxt     = {1'b1, col, row};
              hold_cnt_nxt  = '0;
              rep_phase_nxt = 1'b1;
            end
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
`ifdef KEYPAD_REPEAT_EN
            hold_cnt_nxt = '0;
`endif
            if (cnt_nxt == CW'(DEBOUNCE_CNT)) begin
              cnt_nxt   = '0;
              state_nxt = SCAN;
              col_nxt   = col + 2'd1;
            end
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model drives rows from the scanned column.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] rows, columns, rows_m, rows_force;
  logic [4:0] value;
  logic       force_en;
  logic [15:0] keys;      // index col*4+row

  int cyc = 0;
  int ev_cnt, long_cnt;
  int ev_cyc[16];
  logic [4:0] last_code;
  logic prev_nz = 1'b0;
  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  always_comb begin
    rows_m = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!columns[c] && keys[c*4+r]) rows_m[r] = 1'b0;
  end
  assign rows = force_en ? rows_force : rows_m;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(5), .REPEAT_RATE(2)) dut (
    .clock(clock), .reset_n(reset_n), .rows(rows), .columns(columns), .value(value)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (value != 5'd0) begin
      if (prev_nz) long_cnt++;
      if (ev_cnt < 16) ev_cyc[ev_cnt] = cyc;
      ev_cnt++;
      last_code = value;
    end
    prev_nz = (value != 5'd0);
  end

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    ev_cnt = 0; long_cnt = 0; last_code = 5'd0;
    for (int i = 0; i < 16; i++) ev_cyc[i] = -1000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; keys = '0;
    clk(3);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    force_en = 1'b1; keys = '0; reset_n = 1'b0;
    clear_log();
    for (int i = 0; i < 8; i++) begin
      rows_force = 4'($urandom);
      clk(1);
      checks++; if (columns !== 4'b1110) $display("FAIL reset_columns: got %b want 1110", columns); else passed++;
      checks++; if (value !== 5'd0) $display("FAIL reset_value: got %b want 00000", value); else passed++;
    end
    force_en = 1'b0;
    clk(2);
    reset_n = 1'b1;
    clk(3);
    checks++; if (columns !== 4'b1110) $display("FAIL post_reset_col0: got %b want 1110", columns); else passed++;
    clk(1);
    checks++; if (columns !== 4'b1101) $display("FAIL post_reset_col1: got %b want 1101", columns); else passed++;
  endtask

  task automatic test_clean_press();
    int p;
    do_reset(); clear_log(); clk(5);
    keys[1] = 1'b1; p = cyc;
    clk(200);
    keys = '0;
    for (int i = 0; i < 100 && columns == 4'b1110; i++) clk(1);
    checks++; if (columns !== 4'b1101) $display("FAIL clean_resume_col: got %b want 1101", columns); else passed++;
    clk(20);
    checks++; if (ev_cnt !== 1) $display("FAIL clean_count: got %0d want 1", ev_cnt); else passed++;
    checks++; if (last_code !== 5'b10001) $display("FAIL clean_code: got %b want 10001", last_code); else passed++;
    checks++; if (long_cnt !== 0) $display("FAIL clean_width: got %0d long pulses want 0", long_cnt); else passed++;
    checks++;
    if (ev_cyc[0] - p < 11 || ev_cyc[0] - p > 27)
      $display("FAIL clean_latency: got %0d want 11..27", ev_cyc[0] - p);
    else passed++;
  endtask

  task automatic test_bounce();
    int s;
    do_reset(); clear_log(); clk(5);
    for (int i = 0; i < 10; i++) begin
      keys[5] = ~keys[5];
      clk(3);
    end
    checks++; if (ev_cnt !== 0) $display("FAIL bounce_quiet: got %0d events want 0", ev_cnt); else passed++;
    clk(8);
    keys[5] = 1'b1; s = cyc;
    clk(60);
    keys = '0;
    clk(30);
    checks++; if (ev_cnt !== 1) $display("FAIL bounce_count: got %0d want 1", ev_cnt); else passed++;
    checks++; if (last_code !== 5'b10101) $display("FAIL bounce_code: got %b want 10101", last_code); else passed++;
    checks++;
    if (ev_cyc[0] - s < 11 || ev_cyc[0] - s > 27)
      $display("FAIL bounce_latency: got %0d want 11..27", ev_cyc[0] - s);
    else passed++;
  endtask

  task automatic test_two_key();
    do_reset(); clear_log(); clk(5);
    keys[4] = 1'b1; keys[6] = 1'b1;
    clk(60);
    checks++; if (ev_cnt !== 1) $display("FAIL two_key_count: got %0d want 1", ev_cnt); else passed++;
    checks++; if (last_code !== 5'b10100) $display("FAIL two_key_code: got %b want 10100", last_code); else passed++;
    keys[13] = 1'b1;
    clk(60);
    checks++; if (ev_cnt !== 1) $display("FAIL held_ignore_b: got %0d events want 1", ev_cnt); else passed++;
    keys = '0;
    clk(40);
    keys[13] = 1'b1;
    clk(60);
    keys = '0;
    clk(30);
    checks++; if (ev_cnt !== 2) $display("FAIL b_count: got %0d want 2", ev_cnt); else passed++;
    checks++; if (last_code !== 5'b11101) $display("FAIL b_code: got %b want 11101", last_code); else passed++;
    checks++; if (long_cnt !== 0) $display("FAIL two_key_width: got %0d long pulses want 0", long_cnt); else passed++;
  endtask

  task automatic test_reset_mid_held();
    do_reset(); clear_log(); clk(5);
    keys[10] = 1'b1;
    clk(60);
    checks++; if (ev_cnt !== 1) $display("FAIL k9_count: got %0d want 1", ev_cnt); else passed++;
    checks++; if (last_code !== 5'b11010) $display("FAIL k9_code: got %b want 11010", last_code); else passed++;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk(1);
      checks++; if (value !== 5'd0) $display("FAIL mid_reset_value: got %b want 00000", value); else passed++;
    end
    checks++; if (ev_cnt !== 1) $display("FAIL mid_reset_events: got %0d want 1", ev_cnt); else passed++;
    reset_n = 1'b1;
    clk(60);
    checks++; if (ev_cnt !== 2) $display("FAIL k9_redetect_count: got %0d want 2", ev_cnt); else passed++;
    checks++; if (last_code !== 5'b11010) $display("FAIL k9_redetect_code: got %b want 11010", last_code); else passed++;
    keys = '0;
    clk(30);
  endtask

  task automatic test_repeat();
    do_reset(); clear_log(); clk(5);
    keys[0] = 1'b1;
    for (int i = 0; i < 60 && ev_cnt == 0; i++) clk(1);
    checks++; if (ev_cnt !== 1) $display("FAIL repeat_first: got %0d events want 1 (timeout)", ev_cnt); else passed++;
    clk(77);
    keys = '0;
    clk(40);
    checks++; if (last_code !== 5'b10000) $display("FAIL repeat_code: got %b want 10000", last_code); else passed++;
    checks++; if (long_cnt !== 0) $display("FAIL repeat_width: got %0d long pulses want 0", long_cnt); else passed++;
`ifdef KEYPAD_REPEAT_EN
    checks++; if (ev_cnt !== 9) $display("FAIL repeat_count: got %0d want 9", ev_cnt); else passed++;
    checks++; if (ev_cyc[1] - ev_cyc[0] !== 20) $display("FAIL repeat_delay: got %0d want 20", ev_cyc[1] - ev_cyc[0]); else passed++;
    checks++; if (ev_cyc[2] - ev_cyc[1] !== 8) $display("FAIL repeat_rate1: got %0d want 8", ev_cyc[2] - ev_cyc[1]); else passed++;
    checks++; if (ev_cyc[8] - ev_cyc[7] !== 8) $display("FAIL repeat_rate7: got %0d want 8", ev_cyc[8] - ev_cyc[7]); else passed++;
`else
    checks++; if (ev_cnt !== 1) $display("FAIL no_repeat_count: got %0d want 1", ev_cnt); else passed++;
`endif
  endtask

  initial begin
    reset_n = 1'b0; keys = '0; force_en = 1'b0; rows_force = 4'hF;
    clear_log();
    test_reset();
    test_clean_press();
    test_bounce();
    test_two_key();
    test_reset_mid_held();
    test_repeat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
